lfsr_checker: RTL and testbench
===============================

# lfsr_checker

Receive-side companion to the game's 8-bit LFSR random generator (taps 7,5,4,3, period 255).
- Consumes the 5-bit samples the generator presents on each advance.
- Reconstructs the full 8-bit generator state and locks onto the sequence.
- From then on, predicts every sample and flags mismatches, so RNG integrity is checked in-system and in simulation.
- Sits beside the generator, observing its output and its advance strobe.

## Interface
Parameters:
- LOCK_COUNT, default 4: consecutive correct predictions needed to declare lock (range 1-15).
- LOSS_COUNT, default 3: consecutive mispredictions in LOCKED that drop lock (range 1-15).
- ERR_W, default 16: width of the error counter.

Ports:
- clk_i  input  1  sole clock; all state changes on rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- valid_i  input  1  a new sample is present on rand_i this cycle; no backpressure.
- rand_i  input  5  generator sample, equal to generator state bits [4:0].
- clear_i  input  1  synchronous clear of err_count_o.
- locked_o  output  1  checker is locked to the sequence.
- err_o  output  1  one-cycle pulse for each mispredicted sample while LOCKED.
- err_count_o  output  ERR_W  saturating count of LOCKED mispredictions.

## Operation
- Internal state: expected-state register exp_q[7:0], FSM {SEED, VERIFY, LOCKED}, seed counter (0-3), match counter, miss counter.
- Feedback: fb(x) = x[7]^x[5]^x[4]^x[3]. Successor: nxt(x) = {x[6:0], fb(x)}.
- Nothing changes on cycles with valid_i=0.

SEED:
- First accepted sample: exp_q <= {3'b000, rand_i}, seed counter <= 1.
- Each later sample is checked for shift consistency, rand_i[4:1] == exp_q[3:0].
  - Consistent: exp_q <= {exp_q[6:0], rand_i[0]} and the seed counter increments.
  - Inconsistent: seeding restarts, with this sample as the new first sample (counter = 1).
- The 4th consistent sample completes the seed, and exp_q then holds the true 8-bit state.
  - If the completed exp_q is nonzero: go to VERIFY, match counter = 0.
  - If it is 0x00 (lockup state, unreachable by the generator): restart SEED with counter = 0.

VERIFY:
- Each sample is compared with nxt(exp_q)[4:0].
- Match: exp_q <= nxt(exp_q) and the match counter increments. At LOCK_COUNT matches, go to LOCKED with miss counter = 0.
- Mismatch: go to SEED, with this sample taken as the new first sample.
- No err_o pulse and no count update in VERIFY.

LOCKED:
- exp_q <= nxt(exp_q) on every sample, whether it matches or not. The predictor free-runs, so a single corrupted sample causes one error, not a cascade.
- Match: miss counter = 0.
- Mismatch: err_o pulses, err_count_o increments (saturating at all-ones) and the miss counter increments.
- At LOSS_COUNT consecutive misses: go to SEED with seed counter = 0. The current sample is not reused.

Outputs and counter:
- locked_o is 1 exactly when the FSM is in LOCKED (registered).
- clear_i zeroes err_count_o. If clear_i coincides with a mismatch, clear wins: the count becomes 0, but err_o still pulses.

## Timing
- Reset values: FSM=SEED, all counters 0, exp_q=0x00, locked_o=0, err_o=0, err_count_o=0.
- Reset asserted mid-operation clears everything immediately (asynchronous); lock is lost.
- All outputs are registered.
- A sample accepted at edge N updates err_o, err_count_o and locked_o as seen after edge N.
- err_o is high for exactly one cycle per mispredicted sample; back-to-back mispredictions give a continuous high.
- Throughput: one sample per cycle, with valid_i allowed high continuously.
- Minimum samples from reset to lock: 4 + LOCK_COUNT (8 by default).

## Test plan
- Lock from reset. After reset, feed samples 0x01,0x02,0x04,0x08,0x11,0x03,0x07,0x0E with valid_i gaps between them -> locked_o rises after the 8th sample; err_count_o=0.
- Single corrupted sample. While locked, with the next true sample 0x1C, feed 0x1D, then continue the true sequence -> one err_o pulse, err_count_o=1, locked_o stays 1.
- Loss of lock. While locked, feed 3 consecutive wrong samples -> three err_o pulses, err_count_o=3, and locked_o falls after the 3rd. Resume the true stream -> relock after 8 further samples.
- Bad seed. Feed 0x01 then 0x05 (shift-inconsistent), then the consistent continuation of 0x05 -> seeding restarts from 0x05; lock takes 8 samples counted from 0x05.
- Verify failure. After seed 0x01,0x02,0x04,0x08, feed 0x11 then 0x00 -> return to SEED; no err_o pulse; locked_o stays 0.
- Counter behaviour. Use ERR_W=2 and 5 isolated errors -> err_count_o saturates at 3. Assert clear_i together with a mismatch -> count 0, err_o pulses. Assert rst_ni low mid-lock -> all outputs 0 immediately.

Source files
------------

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 8-bit game LFSR (taps 7,5,4,3).
// It rebuilds the generator state from 5-bit samples, locks onto the sequence and flags mispredicted samples.
module lfsr_checker #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3,
    parameter int unsigned ERR_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [4:0]       rand_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [ERR_W-1:0] err_count_o
);

    typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_e;

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

    state_e           state_q, state_d;
    logic [7:0]       exp_q, exp_d;
    logic [1:0]       seed_cnt_q, seed_cnt_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [3:0]       miss_cnt_q, miss_cnt_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic [7:0] pred;
    logic [7:0] shifted;
    logic       hit;
    logic       consistent;

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    assign pred       = lfsr_next(exp_q);
    assign hit        = (rand_i == pred[4:0]);
    assign shifted    = {exp_q[6:0], rand_i[0]};
    assign consistent = (rand_i[4:1] == exp_q[3:0]);

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        seed_cnt_d  = seed_cnt_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_d       = 1'b0;

        if (valid_i) begin
            unique case (state_q)
                SEED: begin
                    if (seed_cnt_q == 2'd0 || !consistent) begin
                        exp_d      = {3'b000, rand_i};
                        seed_cnt_d = 2'd1;
                    end else begin
                        exp_d = shifted;
                        if (seed_cnt_q == 2'd3) begin
                            // An all-zero seed is the LFSR lockup state; start over.
                            seed_cnt_d = 2'd0;
                            if (shifted != 8'h00) begin
                                state_d     = VERIFY;
                                match_cnt_d = 4'd0;
                            end
                        end else begin
                            seed_cnt_d = seed_cnt_q + 2'd1;
                        end
                    end
                end
                VERIFY: begin
                    if (hit) begin
                        exp_d = pred;
                        if (match_cnt_q + 4'd1 == LOCK_N) begin
                            state_d     = LOCKED;
                            match_cnt_d = 4'd0;
                            miss_cnt_d  = 4'd0;
                        end else begin
                            match_cnt_d = match_cnt_q + 4'd1;
                        end
                    end else begin
                        state_d     = SEED;
                        exp_d       = {3'b000, rand_i};
                        seed_cnt_d  = 2'd1;
                        match_cnt_d = 4'd0;
                    end
                end
                LOCKED: begin
                    // Free-running predictor: a corrupted sample does not derail later predictions.
                    exp_d = pred;
                    if (hit) begin
                        miss_cnt_d = 4'd0;
                    end else begin
                        err_d = 1'b1;
                        if (miss_cnt_q + 4'd1 == LOSS_N) begin
                            state_d    = SEED;
                            seed_cnt_d = 2'd0;
                            miss_cnt_d = 4'd0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 4'd1;
                        end
                    end
                end
                default: state_d = SEED;
            endcase
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clear_i) begin
            err_cnt_d = '0;
        end else if (err_d && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= SEED;
            exp_q       <= 8'h00;
            seed_cnt_q  <= 2'd0;
            match_cnt_q <= 4'd0;
            miss_cnt_q  <= 4'd0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            seed_cnt_q  <= seed_cnt_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked_o    = (state_q == LOCKED);
    assign err_o       = err_q;
    assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: directed samples with hand-worked expected responses.
// A second instance with a 2-bit error counter checks saturation on the same stream.
module tb_lfsr_checker;

    logic        clk;
    logic        rst_ni;
    logic        valid_i;
    logic [4:0]  rand_i;
    logic        clear_i;
    logic        locked_o;
    logic        err_o;
    logic [15:0] err_count_o;
    logic        locked2;
    logic        err2;
    logic [1:0]  count2;

    typedef struct packed {
        logic        locked;
        logic        err;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } resp_t;

    resp_t      expQ[$];
    int         testsRun = 0;
    int         testsFailed = 0;
    int         sampleNo = 0;
    logic [7:0] gen;

    lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .rand_i(rand_i),
        .clear_i(clear_i), .locked_o(locked_o), .err_o(err_o), .err_count_o(err_count_o)
    );

    lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_W(2)) dutSmall (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .rand_i(rand_i),
        .clear_i(clear_i), .locked_o(locked2), .err_o(err2), .err_count_o(count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] genNext(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s (sample %0d): got %0d, expected %0d", name, sampleNo, actual, expected);
        end
    endtask

    // Drive one sample for a cycle and queue the response it should produce.
    task automatic applyStimulus(input logic [4:0] sample, input logic clr,
                                 input logic expLocked, input logic expErr, input int expCount);
        resp_t r;
        r.locked = expLocked;
        r.err    = expErr;
        r.cnt    = 16'(expCount);
        r.cnt2   = 2'((expCount > 3) ? 3 : expCount);
        expQ.push_back(r);
        valid_i = 1'b1;
        rand_i  = sample;
        clear_i = clr;
        @(negedge clk);
        clear_i = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic sendTrue(input logic expLocked, input int expCount);
        logic [4:0] s;
        s   = gen[4:0];
        gen = genNext(gen);
        applyStimulus(s, 1'b0, expLocked, 1'b0, expCount);
    endtask

    task automatic sendWrong(input logic clr, input logic expLocked, input int expCount);
        logic [4:0] s;
        s   = gen[4:0] ^ 5'h1F;
        gen = genNext(gen);
        applyStimulus(s, clr, expLocked, 1'b1, expCount);
    endtask

    task automatic doReset();
        valid_i = 1'b0;
        rst_ni  = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    // Monitor: every accepted sample yields one response, compared one cycle-fraction after the edge.
    initial begin
        resp_t r;
        forever begin
            @(posedge clk);
            if (valid_i && rst_ni) begin
                #1;
                sampleNo++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedSample", 1, 0);
                end else begin
                    r = expQ.pop_front();
                    checkOutput("locked",    int'(locked_o),    int'(r.locked));
                    checkOutput("err",       int'(err_o),       int'(r.err));
                    checkOutput("errCount",  int'(err_count_o), int'(r.cnt));
                    checkOutput("locked2",   int'(locked2),     int'(r.locked));
                    checkOutput("err2",      int'(err2),        int'(r.err));
                    checkOutput("errCount2", int'(count2),      int'(r.cnt2));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [4:0] lockSeq [8];
        lockSeq = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h11, 5'h03, 5'h07, 5'h0E};
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        rand_i  = 5'h00;
        clear_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        checkOutput("resetLocked",   int'(locked_o),    0);
        checkOutput("resetErr",      int'(err_o),       0);
        checkOutput("resetErrCount", int'(err_count_o), 0);

        $display("[TB] lock from reset with gaps");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(lockSeq[i], 1'b0, (i == 7), 1'b0, 0);
            idle(2);
        end
        gen = 8'h1C;

        $display("[TB] single corrupted sample");
        applyStimulus(5'h1D, 1'b0, 1'b1, 1'b1, 1);
        gen = genNext(gen);
        for (int i = 0; i < 4; i++) sendTrue(1'b1, 1);
        idle(1);

        $display("[TB] loss of lock and relock");
        sendWrong(1'b0, 1'b1, 2);
        sendWrong(1'b0, 1'b1, 3);
        sendWrong(1'b0, 1'b0, 4);
        for (int i = 0; i < 8; i++) sendTrue((i == 7), 4);
        idle(1);

        $display("[TB] counter clear and saturation");
        applyStimulus(gen[4:0], 1'b1, 1'b1, 1'b0, 0);
        gen = genNext(gen);
        for (int k = 1; k <= 5; k++) begin
            sendWrong(1'b0, 1'b1, k);
            sendTrue(1'b1, k);
        end
        sendWrong(1'b1, 1'b1, 0);
        sendTrue(1'b1, 0);

        $display("[TB] asynchronous reset mid-lock");
        begin
            resp_t r;
            r.locked = 1'b1;
            r.err    = 1'b1;
            r.cnt    = 16'd1;
            r.cnt2   = 2'd1;
            expQ.push_back(r);
            valid_i = 1'b1;
            rand_i  = gen[4:0] ^ 5'h1F;
            gen     = genNext(gen);
            @(posedge clk);
            #3;
            rst_ni = 1'b0;
            #1;
            checkOutput("asyncRstLocked",    int'(locked_o),    0);
            checkOutput("asyncRstErr",       int'(err_o),       0);
            checkOutput("asyncRstErrCount",  int'(err_count_o), 0);
            checkOutput("asyncRstErrCount2", int'(count2),      0);
            @(negedge clk);
            valid_i = 1'b0;
            @(negedge clk);
            rst_ni = 1'b1;
        end

        $display("[TB] bad seed restarts from second sample");
        applyStimulus(5'h01, 1'b0, 1'b0, 1'b0, 0);
        gen = 8'h25;
        for (int i = 0; i < 8; i++) sendTrue((i == 7), 0);
        idle(1);

        $display("[TB] verify failure reuses sample as new seed");
        doReset();
        applyStimulus(5'h01, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(5'h02, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(5'h04, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(5'h08, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(5'h11, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(5'h00, 1'b0, 1'b0, 1'b0, 0);
        gen = 8'hC0;
        for (int i = 0; i < 7; i++) sendTrue((i == 6), 0);
        idle(3);

        checkOutput("queueDrained", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
